abl: RTL and testbench

- Address Bus Low stage of the 65C02 address path; computes the next ABL each cycle from a microcode-selected base plus offset.
- Holds the registered ABL and the low program counter byte (PCL).
- Produces the registered carry (CO) and offset sign (SGN) that the high-byte stage (abh) consumes on the following cycle as its CI and for its "+CI" / "-1+CI" selection.
- Also produces the PC low-byte increment carry for the PCH increment.

---
 rtl/abl.sv | 96 +++++++++
 tb/tb_abl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/abl.sv
// Address Bus Low stage: next ABL from base + offset, PCL register, carry/sign to abh.
// Ports: clk, rst_n, rdy, DB, REG, op, ld_pc, inc_pc -> ADL, ABL, PCL, CO, SGN, pc_co.
module abl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic [7:0] DB,
  input  logic [7:0] REG,
  input  logic [3:0] op,
  input  logic       ld_pc,
  input  logic       inc_pc,
  output logic [7:0] ADL,
  output logic [7:0] ABL,
  output logic [7:0] PCL,
  output logic       CO,
  output logic       SGN,
  output logic       pc_co
);

  logic [7:0] abl_q, abl_d;
  logic [7:0] pcl_q, pcl_d;
  logic       co_q, co_d;
  logic       sgn_q, sgn_d;

  logic [7:0] base;
  logic [7:0] offs;
  logic       cin;
  logic [8:0] sum;

  always_comb begin
    base = 8'h00;
    unique case (op[3:2])
      2'b00: base = 8'h00;
      2'b01: base = abl_q;
      2'b10: base = pcl_q;
      2'b11: base = DB;
      default: base = 8'h00;
    endcase
  end

  always_comb begin
    offs = 8'h00;
    unique case (op[1:0])
      2'b00: offs = 8'h00;
      2'b01: offs = 8'h00;
      2'b10: offs = REG;
      2'b11: offs = DB;
      default: offs = 8'h00;
    endcase
  end

  // Signed branch offsets add as plain bytes; abh
  // corrects the page using SGN and CO.
  always_comb begin
    cin = (op[1:0] == 2'b01);
    sum = {1'b0, base} + {1'b0, offs} + {8'h00, cin};
  end

  always_comb begin
    abl_d = abl_q;
    co_d  = co_q;
    sgn_d = sgn_q;
    pcl_d = pcl_q;
    if (rdy) begin
      abl_d = sum[7:0];
      co_d  = sum[8];
      sgn_d = (op[1:0] == 2'b11) & DB[7];
    end
    // PCL follows ld_pc only, in step with PCH.
    if (ld_pc) begin
      pcl_d = abl_q + {7'h00, inc_pc};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abl_q <= 8'h00;
      pcl_q <= 8'h00;
      co_q  <= 1'b0;
      sgn_q <= 1'b0;
    end else begin
      abl_q <= abl_d;
      pcl_q <= pcl_d;
      co_q  <= co_d;
      sgn_q <= sgn_d;
    end
  end

  assign ADL   = sum[7:0];
  assign ABL   = abl_q;
  assign PCL   = pcl_q;
  assign CO    = co_q;
  assign SGN   = sgn_q;
  assign pc_co = inc_pc & ld_pc & (abl_q == 8'hFF);

endmodule

// File: tb/tb_abl.sv
// Self-checking bench for abl: directed steps then random ops,
// compared against an arithmetic reference model.
module tb_abl;

  logic       clk;
  logic       rst_n;
  logic       rdy;
  logic [7:0] DB;
  logic [7:0] REG;
  logic [3:0] op;
  logic       ld_pc;
  logic       inc_pc;
  logic [7:0] ADL;
  logic [7:0] ABL;
  logic [7:0] PCL;
  logic       CO;
  logic       SGN;
  logic       pc_co;

  int checks = 0;
  int fails  = 0;

  int m_abl = 0;
  int m_pcl = 0;
  int m_co  = 0;
  int m_sgn = 0;

  abl dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .DB(DB), .REG(REG), .op(op),
    .ld_pc(ld_pc), .inc_pc(inc_pc),
    .ADL(ADL), .ABL(ABL), .PCL(PCL),
    .CO(CO), .SGN(SGN), .pc_co(pc_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_sum();
    int b;
    int o;
    case (int'(op[3:2]))
      0: b = 0;
      1: b = m_abl;
      2: b = m_pcl;
      default: b = int'(DB);
    endcase
    case (int'(op[1:0]))
      0: o = 0;
      1: o = 1;
      2: o = int'(REG);
      default: o = int'(DB);
    endcase
    return b + o;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".ABL"}, int'(ABL), m_abl);
    chk({tag, ".PCL"}, int'(PCL), m_pcl);
    chk({tag, ".CO"},  int'(CO),  m_co);
    chk({tag, ".SGN"}, int'(SGN), m_sgn);
  endtask

  task automatic step(input string tag, input logic r,
                      input logic [3:0] o, input logic [7:0] d,
                      input logic [7:0] g, input logic ld,
                      input logic inc);
    int s;
    int exp_pcco;
    @(negedge clk);
    rdy = r; op = o; DB = d; REG = g;
    ld_pc = ld; inc_pc = inc;
    #1;
    s = model_sum();
    exp_pcco = (ld && inc && m_abl == 255) ? 1 : 0;
    chk({tag, ".ADL"}, int'(ADL), s % 256);
    chk({tag, ".pc_co"}, int'(pc_co), exp_pcco);
    @(posedge clk);
    if (ld) m_pcl = (m_abl + (inc ? 1 : 0)) % 256;
    if (r) begin
      m_abl = s % 256;
      m_co  = (s > 255) ? 1 : 0;
      m_sgn = (o[1:0] == 2'b11 && d[7]) ? 1 : 0;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic model_reset();
    m_abl = 0; m_pcl = 0; m_co = 0; m_sgn = 0;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; DB = 8'h00; REG = 8'h00;
    op = 4'b0001; ld_pc = 1'b0; inc_pc = 1'b0;
    #1;
    check_regs("por");
    chk("por.ADL", int'(ADL), 8'h01);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // ABL=5A, CO=1, then reset mid-cycle
    step("pre5a", 1, 4'b1110, 8'hFA, 8'h60, 0, 0);
    chk("pre5a.abl_const", int'(ABL), 8'h5A);
    chk("pre5a.co_const", int'(CO), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step("rel", 1, 4'b1100, 8'h34, 8'h00, 0, 0);
    chk("rel.abl_const", int'(ABL), 8'h34);

    // Indexed page cross
    step("idx", 1, 4'b1110, 8'hF0, 8'h20, 0, 0);
    chk("idx.co_const", int'(CO), 1);

    // Backward branch from PCL=05 then PCL=02
    step("ld05a", 1, 4'b1100, 8'h05, 8'h00, 0, 0);
    step("ld05b", 1, 4'b1100, 8'h05, 8'h00, 1, 0);
    chk("ld05.pcl_const", int'(PCL), 8'h05);
    step("br05", 1, 4'b1011, 8'hFB, 8'h00, 0, 0);
    chk("br05.abl_const", int'(ABL), 8'h00);
    chk("br05.sgn_const", int'(SGN), 1);
    step("ld02a", 1, 4'b1100, 8'h02, 8'h00, 0, 0);
    step("ld02b", 1, 4'b1100, 8'h02, 8'h00, 1, 0);
    step("br02", 1, 4'b1011, 8'hFB, 8'h00, 0, 0);
    chk("br02.abl_const", int'(ABL), 8'hFD);
    chk("br02.co_const", int'(CO), 0);

    // Same-page signed cases
    step("ld10a", 1, 4'b1100, 8'h10, 8'h00, 0, 0);
    step("ld10b", 1, 4'b1100, 8'h10, 8'h00, 1, 0);
    step("br10", 1, 4'b1011, 8'hF0, 8'h00, 0, 0);
    step("ldf0a", 1, 4'b1100, 8'hF0, 8'h00, 0, 0);
    step("ldf0b", 1, 4'b1100, 8'hF0, 8'h00, 1, 0);
    step("brf0", 1, 4'b1011, 8'hF0, 8'h00, 0, 0);
    chk("brf0.abl_const", int'(ABL), 8'hE0);

    // rdy stall
    step("ld40", 1, 4'b1100, 8'h40, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall", 0, 4'b0101, 8'h00, 8'h00, 0, 0);
      chk("stall.abl_const", int'(ABL), 8'h40);
    end
    step("unstall", 1, 4'b0101, 8'h00, 8'h00, 0, 0);
    chk("unstall.abl_const", int'(ABL), 8'h41);

    // Wraps
    step("dbff", 1, 4'b1101, 8'hFF, 8'h00, 0, 0);
    chk("dbff.co_const", int'(CO), 1);
    step("ldff", 1, 4'b1100, 8'hFF, 8'h00, 0, 0);
    step("pcwrap", 0, 4'b0000, 8'h00, 8'h00, 1, 1);
    chk("pcwrap.pcl_const", int'(PCL), 8'h00);
    step("pcnoinc", 0, 4'b0000, 8'h00, 8'h00, 1, 0);
    chk("pcnoinc.pcl_const", int'(PCL), 8'hFF);
    step("pchold", 1, 4'b0000, 8'h00, 8'h00, 0, 1);
    chk("pchold.pcl_const", int'(PCL), 8'hFF);
    step("ldff2", 1, 4'b1100, 8'hFF, 8'h00, 0, 0);
    step("ablinc", 1, 4'b0101, 8'h00, 8'h00, 1, 1);
    chk("ablinc.pcl_old", int'(PCL), 8'h00);
    chk("ablinc.co_const", int'(CO), 1);

    // Zero base
    step("z1", 1, 4'b0001, 8'h00, 8'h00, 0, 0);
    step("z0", 1, 4'b0000, 8'hFF, 8'hFF, 0, 0);

    // Random
    for (int i = 0; i < 300; i++) begin
      step("rnd", ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), 8'($urandom),
           8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
